// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding and starvation defaults for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY_IF = 2'b01,
        BUSY_DM = 2'b10
    } arb_state_t;

    localparam int STARVE_MAX_DEFAULT = 3;

    // Counter width wide enough to hold STARVE_MAX, kept within 2..4 bits
    function automatic int starve_width(input int smax);
        int w;
        w = $clog2(smax + 1);
        return (w < 2) ? 2 : (w > 4) ? 4 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and data access, data first with starvation guard
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       if_req,
    input  logic [7:0] if_addr,
    output logic [7:0] if_rdata,
    output logic       if_valid,
    input  logic       dm_req,
    input  logic       dm_we,
    input  logic [7:0] dm_addr,
    input  logic [7:0] dm_wdata,
    output logic [7:0] dm_rdata,
    output logic       dm_valid,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic       stall_fetch,
    output logic       stall_mem
);

    localparam int CW = starve_width(STARVE_MAX);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    arb_state_t    state, state_d;
    logic [CW-1:0] starve_cnt, starve_d;
    logic [7:0]    addr_q, wdata_q;
    logic          we_q;
    logic          ack_if, ack_dm, grant_if, grant_dm;

    // Arbitration: idle favours data unless fetch is starved; an ack hands the port straight to the other requester
    always_comb begin
        ack_if   = mem_ack && state == BUSY_IF;
        ack_dm   = mem_ack && state == BUSY_DM;
        grant_if = (state == IDLE && if_req && (!dm_req || starve_cnt == SMAX)) || (ack_dm && if_req);
        grant_dm = (state == IDLE && dm_req && !grant_if) || (ack_if && dm_req);
        state_d  = grant_if ? BUSY_IF : grant_dm ? BUSY_DM : (ack_if || ack_dm) ? IDLE : state;
        starve_d = (!if_req || grant_if) ? '0 :
                   (grant_dm && starve_cnt != SMAX) ? starve_cnt + 1'b1 : starve_cnt;
    end

    // State register; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    // Access latch and starvation counter; the latched access is held steady until its ack
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
        end else begin
            starve_cnt <= starve_d;
            if (grant_if) begin
                addr_q  <= if_addr;
                wdata_q <= '0;
                we_q    <= 1'b0;
            end else if (grant_dm) begin
                addr_q  <= dm_addr;
                wdata_q <= dm_wdata;
                we_q    <= dm_we;
            end
        end
    end

    assign mem_req     = state != IDLE;
    assign mem_we      = state == BUSY_DM && we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign if_valid    = ack_if;
    assign dm_valid    = ack_dm;
    assign if_rdata    = ack_if ? mem_rdata : '0;
    assign dm_rdata    = (ack_dm && !we_q) ? mem_rdata : '0;
    assign stall_fetch = if_req && !ack_if;
    assign stall_mem   = dm_req && !ack_dm;

endmodule
